// File: rtl/fb_bank_ctrl.sv
// Ping-pong framebuffer controller: maps front-end pixels to RAM writes and hands complete frames to the reader.
// Write port is registered (one cycle after acceptance); the reader is never blocked, and surplus frames are dropped.
module fb_bank_ctrl #(
    parameter int PIX_COLS    = 8,
    parameter int PIX_LINES   = 16,
    parameter int BLOCK_COLS  = 5,
    parameter int BLOCK_LINES = 3,
    parameter int AW          = 11,
    parameter int DW          = 24
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [DW-1:0] pixel_data,
    input  logic          pixel_valid,
    input  logic [2:0]    pixel_col,
    input  logic [3:0]    pixel_line,
    input  logic [2:0]    block_col,
    input  logic [1:0]    block_line,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          rd_bank,
    input  logic          rd_swap_req,
    output logic          rd_swap_ack,
    output logic          frame_ready,
    output logic          frame_drop,
    output logic          frame_error
);
    localparam int N  = PIX_COLS * PIX_LINES * BLOCK_COLS * BLOCK_LINES;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {WAIT_SOF, FILL, FULL} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   count, count_n;
    logic            wr_en_n, wr_bank_n, rd_bank_n;
    logic [AW-1:0]   wr_addr_n, addr;
    logic [DW-1:0]   wr_data_n;
    logic            ready_n, ack_n, drop_n, err_n;
    logic            pix_ok, is_sof, is_last, do_write;

    // block_line 3 lies outside the frame, so such pixels are treated as absent
    assign pix_ok  = pixel_valid && (block_line != 2'd3);
    assign is_sof  = pix_ok && (pixel_col == 3'd0) && (pixel_line == 4'd0)
                     && (block_col == 3'd0) && (block_line == 2'd0);
    assign is_last = pix_ok && (pixel_col == 3'(PIX_COLS - 1)) && (pixel_line == 4'(PIX_LINES - 1))
                     && (block_col == 3'(BLOCK_COLS - 1)) && (block_line == 2'(BLOCK_LINES - 1));
    assign addr = ((AW'(block_line) * AW'(BLOCK_COLS) + AW'(block_col)) * AW'(PIX_LINES)
                   + AW'(pixel_line)) * AW'(PIX_COLS) + AW'(pixel_col);

    always_comb begin
        state_n   = state;
        count_n   = count;
        wr_bank_n = wr_bank;
        rd_bank_n = rd_bank;
        ready_n   = frame_ready;
        ack_n     = 1'b0;
        drop_n    = 1'b0;
        err_n     = 1'b0;
        do_write  = 1'b0;
        case (state)
            WAIT_SOF: begin
                if (is_sof) begin
                    do_write = 1'b1;
                    count_n  = CW'(1);
                    state_n  = FILL;
                end
            end
            FILL: begin
                if (is_sof) begin
                    err_n    = 1'b1;
                    do_write = 1'b1;
                    count_n  = CW'(1);
                end else if (is_last) begin
                    if (count == CW'(N - 1)) begin
                        do_write = 1'b1;
                        count_n  = CW'(N);
                        ready_n  = 1'b1;
                        state_n  = FULL;
                    end else begin
                        err_n   = 1'b1;
                        count_n = '0;
                        state_n = WAIT_SOF;
                    end
                end else if (pix_ok) begin
                    do_write = 1'b1;
                    count_n  = (count == CW'(N)) ? count : count + CW'(1);
                end
            end
            FULL: begin
                // a swap frees a bank, so an SOF arriving with it starts the next frame
                if (rd_swap_req && frame_ready) begin
                    rd_bank_n = wr_bank;
                    wr_bank_n = ~wr_bank;
                    ready_n   = 1'b0;
                    ack_n     = 1'b1;
                    count_n   = '0;
                    state_n   = WAIT_SOF;
                    if (is_sof) begin
                        do_write = 1'b1;
                        count_n  = CW'(1);
                        state_n  = FILL;
                    end
                end else if (is_sof) begin
                    drop_n = 1'b1;
                end
            end
            default: state_n = WAIT_SOF;
        endcase
        wr_en_n   = do_write;
        wr_addr_n = do_write ? addr : wr_addr;
        wr_data_n = do_write ? pixel_data : wr_data;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= WAIT_SOF;
            count       <= '0;
            wr_en       <= 1'b0;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b1;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_swap_ack <= 1'b0;
            frame_ready <= 1'b0;
            frame_drop  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            wr_en       <= wr_en_n;
            wr_bank     <= wr_bank_n;
            rd_bank     <= rd_bank_n;
            wr_addr     <= wr_addr_n;
            wr_data     <= wr_data_n;
            rd_swap_ack <= ack_n;
            frame_ready <= ready_n;
            frame_drop  <= drop_n;
            frame_error <= err_n;
        end
    end
endmodule
